// File: rtl/timer_pkg.sv
// Shared definitions for the timer register bank: register offsets, TCR field
// positions, the default divider limit, reset constants and a byte-merge helper.
package timer_pkg;

    localparam int unsigned DIV_MAX_DEF = 8;

    localparam logic [31:0] TCR_A   = 32'h00;
    localparam logic [31:0] TDR0_A  = 32'h04;
    localparam logic [31:0] TDR1_A  = 32'h08;
    localparam logic [31:0] TCMP0_A = 32'h0C;
    localparam logic [31:0] TCMP1_A = 32'h10;
    localparam logic [31:0] TIER_A  = 32'h14;
    localparam logic [31:0] TISR_A  = 32'h18;
    localparam logic [31:0] THCSR_A = 32'h1C;

    localparam int unsigned TCR_EN_BIT      = 0;
    localparam int unsigned TCR_DIV_EN_BIT  = 1;
    localparam int unsigned TCR_DIV_VAL_LSB = 8;
    localparam int unsigned DIV_VAL_W       = 4;

    localparam logic [31:0] TCR_RST  = 32'h0000_0100;
    localparam logic [31:0] TCMP_RST = 32'hFFFF_FFFF;

    typedef enum logic [3:0] {
        SEL_NONE,
        SEL_TCR,
        SEL_TDR0,
        SEL_TDR1,
        SEL_TCMP0,
        SEL_TCMP1,
        SEL_TIER,
        SEL_TISR,
        SEL_THCSR
    } reg_sel_e;

    // Replace only the bytes whose strobe is set.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        res = old_val;
        for (int unsigned i = 0; i < 4; i++) begin
            if (strb[i]) res[8*i +: 8] = new_val[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/timer_counter.sv
// Prescaler and 64-bit free-running counter with per-byte parallel load.
// A load in any byte suppresses the increment for that cycle.
module timer_counter
    import timer_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cnt_en,
    input  logic                 div_en,
    input  logic [DIV_VAL_W-1:0] div_val,
    input  logic [7:0]           ld_en,
    input  logic [63:0]          ld_data,
    output logic [63:0]          cnt
);

    logic [15:0] div_q, div_d;
    logic [15:0] div_limit;
    logic        div_wrap;
    logic        inc;
    logic [63:0] cnt_q, cnt_d;

    // Divider runs 0..2^div_val-1 while counting with the prescaler on; otherwise held at 0.
    always_comb begin
        div_limit = (16'd1 << div_val) - 16'd1;
        div_wrap  = (div_q == div_limit);
        div_d     = div_q;
        if (!cnt_en || !div_en) begin
            div_d = '0;
        end else if (div_wrap) begin
            div_d = '0;
        end else begin
            div_d = div_q + 16'd1;
        end
        inc = cnt_en & (~div_en | div_wrap);
    end

    // Counter next value: byte loads win over the increment.
    always_comb begin
        cnt_d = cnt_q;
        if (|ld_en) begin
            for (int unsigned i = 0; i < 8; i++) begin
                if (ld_en[i]) cnt_d[8*i +: 8] = ld_data[8*i +: 8];
            end
        end else if (inc) begin
            cnt_d = cnt_q + 64'd1;
        end
    end

    // Divider and counter state.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_q <= '0;
            cnt_q <= '0;
        end else begin
            div_q <= div_d;
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/timer_regfile_counter.sv
// Timer register bank: APB decode, TCR/TCMP/TIER/TISR/THCSR registers, slave
// error generation and the level interrupt. Counting lives in timer_counter.
// Optional debug halt is enabled by defining TIMER_DBG_HALT_EN.
module timer_regfile_counter
    import timer_pkg::*;
#(
    parameter int unsigned ADDR_W  = 12,
    parameter int unsigned DIV_MAX = DIV_MAX_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic              rd_en,
    input  logic              pready,
    input  logic [ADDR_W-1:0] paddr,
    input  logic [31:0]       pwdata,
    input  logic [3:0]        pstrb,
    input  logic              dbg_mode,
    output logic [31:0]       prdata,
    output logic              pslverr,
    output logic              tim_int
);

    reg_sel_e              sel;
    logic [31:0]           addr32;
    logic                  commit;

    logic                  tcr_en_q, tcr_en_d;
    logic                  div_en_q, div_en_d;
    logic [DIV_VAL_W-1:0]  div_val_q, div_val_d;
    logic [63:0]           cmp_q, cmp_d;
    logic                  int_en_q, int_en_d;
    logic                  int_st_q, int_st_d;

    logic [31:0]           tcr_cur, tcr_new;
    logic                  tcr_err;
    logic                  halted;
    logic [1:0]            thcsr_rd;
    logic                  cnt_en;
    logic [7:0]            ld_en;
    logic [63:0]           cnt;

    assign commit = wr_en & pready;
    assign addr32 = 32'(paddr);

    // Address decode.
    always_comb begin
        sel = SEL_NONE;
        case (addr32)
            TCR_A:   sel = SEL_TCR;
            TDR0_A:  sel = SEL_TDR0;
            TDR1_A:  sel = SEL_TDR1;
            TCMP0_A: sel = SEL_TCMP0;
            TCMP1_A: sel = SEL_TCMP1;
            TIER_A:  sel = SEL_TIER;
            TISR_A:  sel = SEL_TISR;
            THCSR_A: sel = SEL_THCSR;
            default: sel = SEL_NONE;
        endcase
    end

    // TCR legality: div_val bound and no prescaler change while running.
    always_comb begin
        tcr_cur = '0;
        tcr_cur[TCR_EN_BIT]                        = tcr_en_q;
        tcr_cur[TCR_DIV_EN_BIT]                    = div_en_q;
        tcr_cur[TCR_DIV_VAL_LSB +: DIV_VAL_W]      = div_val_q;
        tcr_new = merge_bytes(tcr_cur, pwdata, pstrb);
        tcr_err = (32'(tcr_new[TCR_DIV_VAL_LSB +: DIV_VAL_W]) > DIV_MAX) ||
                  (tcr_en_q && ((tcr_new[TCR_DIV_EN_BIT] != div_en_q) ||
                                (tcr_new[TCR_DIV_VAL_LSB +: DIV_VAL_W] != div_val_q)));
    end

    assign pslverr = commit & (sel == SEL_TCR) & tcr_err;

`ifdef TIMER_DBG_HALT_EN
    logic halt_req_q, halt_req_d;

    // Halt request register.
    always_comb begin
        halt_req_d = halt_req_q;
        if (commit && sel == SEL_THCSR && pstrb[0]) halt_req_d = pwdata[0];
    end

    // Halt request state.
    always_ff @(posedge clk) begin
        if (rst) halt_req_q <= 1'b0;
        else     halt_req_q <= halt_req_d;
    end

    assign halted   = halt_req_q & dbg_mode;
    assign thcsr_rd = {halted, halt_req_q};
`else
    logic unused_dbg_mode;
    assign unused_dbg_mode = dbg_mode;
    assign halted          = 1'b0;
    assign thcsr_rd        = 2'b00;
`endif

    assign cnt_en = tcr_en_q & ~halted;
    assign ld_en  = {(commit && sel == SEL_TDR1) ? pstrb : 4'b0000,
                     (commit && sel == SEL_TDR0) ? pstrb : 4'b0000};

    timer_counter u_counter (
        .clk     (clk),
        .rst     (rst),
        .cnt_en  (cnt_en),
        .div_en  (div_en_q),
        .div_val (div_val_q),
        .ld_en   (ld_en),
        .ld_data ({pwdata, pwdata}),
        .cnt     (cnt)
    );

    // Register next-state: APB writes, plus compare-match setting int_st over a same-cycle clear.
    always_comb begin
        tcr_en_d  = tcr_en_q;
        div_en_d  = div_en_q;
        div_val_d = div_val_q;
        cmp_d     = cmp_q;
        int_en_d  = int_en_q;
        int_st_d  = int_st_q;
        if (commit) begin
            case (sel)
                SEL_TCR: begin
                    if (!tcr_err) begin
                        tcr_en_d  = tcr_new[TCR_EN_BIT];
                        div_en_d  = tcr_new[TCR_DIV_EN_BIT];
                        div_val_d = tcr_new[TCR_DIV_VAL_LSB +: DIV_VAL_W];
                    end
                end
                SEL_TCMP0: cmp_d[31:0]  = merge_bytes(cmp_q[31:0], pwdata, pstrb);
                SEL_TCMP1: cmp_d[63:32] = merge_bytes(cmp_q[63:32], pwdata, pstrb);
                SEL_TIER:  if (pstrb[0]) int_en_d = pwdata[0];
                SEL_TISR:  if (pstrb[0] && pwdata[0]) int_st_d = 1'b0;
                default: ;
            endcase
        end
        if (cnt == cmp_q) int_st_d = 1'b1;
    end

    // Register state.
    always_ff @(posedge clk) begin
        if (rst) begin
            tcr_en_q  <= TCR_RST[TCR_EN_BIT];
            div_en_q  <= TCR_RST[TCR_DIV_EN_BIT];
            div_val_q <= TCR_RST[TCR_DIV_VAL_LSB +: DIV_VAL_W];
            cmp_q     <= {TCMP_RST, TCMP_RST};
            int_en_q  <= 1'b0;
            int_st_q  <= 1'b0;
        end else begin
            tcr_en_q  <= tcr_en_d;
            div_en_q  <= div_en_d;
            div_val_q <= div_val_d;
            cmp_q     <= cmp_d;
            int_en_q  <= int_en_d;
            int_st_q  <= int_st_d;
        end
    end

    // Read mux: zero unless a read is in progress.
    always_comb begin
        prdata = '0;
        if (rd_en) begin
            case (sel)
                SEL_TCR:   prdata = tcr_cur;
                SEL_TDR0:  prdata = cnt[31:0];
                SEL_TDR1:  prdata = cnt[63:32];
                SEL_TCMP0: prdata = cmp_q[31:0];
                SEL_TCMP1: prdata = cmp_q[63:32];
                SEL_TIER:  prdata = {31'b0, int_en_q};
                SEL_TISR:  prdata = {31'b0, int_st_q};
                SEL_THCSR: prdata = {30'b0, thcsr_rd};
                default:   prdata = '0;
            endcase
        end
    end

    assign tim_int = int_st_q & int_en_q;

endmodule

// File: tb/tb_timer_regfile_counter.sv
// Self-checking bench for timer_regfile_counter (both TIMER_DBG_HALT_EN builds).
module tb_timer_regfile_counter;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en, rd_en, pready;
    logic [11:0] paddr;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic        dbg_mode;
    logic [31:0] prdata;
    logic        pslverr;
    logic        tim_int;

    int compared   = 0;
    int mismatched = 0;

    timer_regfile_counter #(.ADDR_W(12), .DIV_MAX(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .rd_en    (rd_en),
        .pready   (pready),
        .paddr    (paddr),
        .pwdata   (pwdata),
        .pstrb    (pstrb),
        .dbg_mode (dbg_mode),
        .prdata   (prdata),
        .pslverr  (pslverr),
        .tim_int  (tim_int)
    );

    always #5 clk = ~clk;

`ifdef TIMER_DBG_HALT_EN
    localparam bit HALT = 1'b1;
`else
    localparam bit HALT = 1'b0;
`endif

    typedef struct {
        string       name;
        logic [31:0] exp;
    } sb_t;
    sb_t sb_q[$];

    typedef struct {
        logic [11:0] addr;
        logic [31:0] exp;
    } rd_vec_t;

    typedef struct {
        logic [11:0] addr;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic        exp_err;
        logic [31:0] exp_rd;
    } wr_vec_t;

    rd_vec_t rvec[9];
    wr_vec_t wvec[16];

    task automatic sb_push(input string n, input logic [31:0] e);
        sb_t t;
        t.name = n;
        t.exp  = e;
        sb_q.push_back(t);
    endtask

    task automatic sb_check(input logic [31:0] act);
        sb_t t;
        if (sb_q.size() == 0) begin
            mismatched++;
            $display("FAIL scoreboard_empty: got 0x%08h, nothing expected", act);
        end else begin
            t = sb_q.pop_front();
            compared++;
            if (act !== t.exp) begin
                mismatched++;
                $display("FAIL %s: got 0x%08h expected 0x%08h", t.name, act, t.exp);
            end
        end
    endtask

    task automatic check_now(input string n, input logic [31:0] act, input logic [31:0] e);
        sb_push(n, e);
        sb_check(act);
    endtask

    task automatic apb_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s,
                             input bit chk, input logic exp_err, input string n);
        @(negedge clk);
        paddr  = a;
        pwdata = d;
        pstrb  = s;
        wr_en  = 1'b1;
        pready = 1'b1;
        if (chk) begin
            sb_push(n, {31'b0, exp_err});
            #1;
            sb_check({31'b0, pslverr});
        end
        @(negedge clk);
        wr_en  = 1'b0;
        pready = 1'b0;
        pstrb  = 4'b0000;
    endtask

    task automatic apb_read(input logic [11:0] a, input logic [31:0] e, input string n);
        @(negedge clk);
        paddr  = a;
        rd_en  = 1'b1;
        pready = 1'b1;
        sb_push(n, e);
        #1;
        sb_check(prdata);
        rd_en  = 1'b0;
        pready = 1'b0;
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d);
        apb_write(a, d, 4'hF, 1'b0, 1'b0, "");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rvec[0] = '{12'h000, 32'h0000_0100};
        rvec[1] = '{12'h004, 32'h0};
        rvec[2] = '{12'h008, 32'h0};
        rvec[3] = '{12'h00C, 32'hFFFF_FFFF};
        rvec[4] = '{12'h010, 32'hFFFF_FFFF};
        rvec[5] = '{12'h014, 32'h0};
        rvec[6] = '{12'h018, 32'h0};
        rvec[7] = '{12'h01C, 32'h0};
        rvec[8] = '{12'h020, 32'h0};

        wvec[0]  = '{12'h00C, 32'hAABB_CCDD, 4'b0101, 1'b0, 32'hFFBB_FFDD};
        wvec[1]  = '{12'h010, 32'h1234_5678, 4'b1111, 1'b0, 32'h1234_5678};
        wvec[2]  = '{12'h014, 32'hFFFF_FFFF, 4'b1111, 1'b0, 32'h0000_0001};
        wvec[3]  = '{12'h014, 32'h0,         4'b0000, 1'b0, 32'h0000_0001};
        wvec[4]  = '{12'h014, 32'h0,         4'b0001, 1'b0, 32'h0};
        wvec[5]  = '{12'h000, 32'h0000_0900, 4'b0010, 1'b1, 32'h0000_0100};
        wvec[6]  = '{12'h000, 32'h0000_0800, 4'b0010, 1'b0, 32'h0000_0800};
        wvec[7]  = '{12'h000, 32'hFFFF_F1FC, 4'b1111, 1'b0, 32'h0000_0100};
        wvec[8]  = '{12'h008, 32'hCAFE_F00D, 4'b1111, 1'b0, 32'hCAFE_F00D};
        wvec[9]  = '{12'h004, 32'h0000_00A5, 4'b0001, 1'b0, 32'h0000_00A5};
        wvec[10] = '{12'h018, 32'hFFFF_FFFF, 4'b1111, 1'b0, 32'h0};
        wvec[11] = '{12'h020, 32'hFFFF_FFFF, 4'b1111, 1'b0, 32'h0};
        wvec[12] = '{12'h01C, 32'h0000_0003, 4'b1111, 1'b0, HALT ? 32'h1 : 32'h0};
        wvec[13] = '{12'h01C, 32'h0,         4'b1111, 1'b0, 32'h0};
        wvec[14] = '{12'h00C, 32'hFFFF_FFFF, 4'b1111, 1'b0, 32'hFFFF_FFFF};
        wvec[15] = '{12'h010, 32'hFFFF_FFFF, 4'b1111, 1'b0, 32'hFFFF_FFFF};

        rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; pready = 1'b0;
        paddr = '0; pwdata = '0; pstrb = '0; dbg_mode = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_now("rst_pslverr", {31'b0, pslverr}, 32'h0);
        check_now("rst_tim_int", {31'b0, tim_int}, 32'h0);
        rst = 1'b0;

        // Reset values of the whole map.
        for (int i = 0; i < 9; i++) apb_read(rvec[i].addr, rvec[i].exp, $sformatf("rst_rd_%03h", rvec[i].addr));
        #1;
        check_now("prdata_idle", prdata, 32'h0);

        // Write / read-back vectors.
        for (int i = 0; i < 16; i++) begin
            apb_write(wvec[i].addr, wvec[i].wdata, wvec[i].strb, 1'b1, wvec[i].exp_err, $sformatf("wr_err_%0d", i));
            apb_read(wvec[i].addr, wvec[i].exp_rd, $sformatf("wr_rd_%0d", i));
        end

        // Plain counting, then illegal prescaler change while running.
        wr(12'h004, 32'h0);
        wr(12'h008, 32'h0);
        wr(12'h000, 32'h0000_0001);
        apb_read(12'h004, 32'd1, "cnt_first");
        repeat (9) @(negedge clk);
        apb_read(12'h004, 32'd11, "cnt_plus10");
        apb_write(12'h000, 32'h0000_0303, 4'hF, 1'b1, 1'b1, "tcr_busy_err");
        apb_read(12'h000, 32'h0000_0001, "tcr_unchanged");

        // Divide by 8.
        apb_write(12'h000, 32'h0, 4'hF, 1'b1, 1'b0, "tcr_disable_ok");
        wr(12'h004, 32'h0);
        wr(12'h008, 32'h0);
        apb_write(12'h000, 32'h0000_0302, 4'hF, 1'b1, 1'b0, "tcr_div_idle_ok");
        apb_write(12'h000, 32'h0000_0303, 4'hF, 1'b1, 1'b0, "tcr_div_en_ok");
        repeat (6) @(negedge clk);
        apb_read(12'h004, 32'd0, "div8_before");
        apb_read(12'h004, 32'd1, "div8_first");
        repeat (6) @(negedge clk);
        apb_read(12'h004, 32'd1, "div8_hold");
        apb_read(12'h004, 32'd2, "div8_second");

        // 64-bit wrap.
        wr(12'h000, 32'h0000_0302);
        wr(12'h000, 32'h0);
        wr(12'h008, 32'hFFFF_FFFF);
        wr(12'h004, 32'hFFFF_FFFE);
        wr(12'h000, 32'h0000_0001);
        apb_read(12'h004, 32'hFFFF_FFFF, "wrap_lo_max");
        apb_read(12'h004, 32'h0, "wrap_lo_zero");
        apb_read(12'h008, 32'h0, "wrap_hi_zero");

        // Compare interrupt and set-over-clear priority.
        wr(12'h000, 32'h0);
        apb_read(12'h018, 32'h1, "int_st_all_ones_match");
        wr(12'h004, 32'h0);
        wr(12'h008, 32'h0);
        wr(12'h00C, 32'd5);
        wr(12'h010, 32'h0);
        wr(12'h018, 32'h1);
        apb_read(12'h018, 32'h0, "int_st_cleared");
        wr(12'h014, 32'h1);
        wr(12'h000, 32'h0000_0001);
        repeat (4) @(negedge clk);
        #1;
        check_now("tim_int_before_match", {31'b0, tim_int}, 32'h0);
        apb_write(12'h018, 32'h1, 4'hF, 1'b1, 1'b0, "w1c_at_match_err");
        #1;
        check_now("tim_int_after_match", {31'b0, tim_int}, 32'h1);
        apb_read(12'h018, 32'h1, "set_beats_clear");
        wr(12'h018, 32'h1);
        apb_read(12'h018, 32'h0, "w1c_clears");
        #1;
        check_now("tim_int_cleared", {31'b0, tim_int}, 32'h0);

        // Debug halt (counts straight through when the feature is absent).
        wr(12'h000, 32'h0);
        wr(12'h004, 32'h0);
        wr(12'h008, 32'h0);
        wr(12'h01C, 32'h1);
        wr(12'h000, 32'h0000_0001);
        repeat (3) @(negedge clk);
        dbg_mode = 1'b1;
        apb_read(12'h01C, HALT ? 32'h3 : 32'h0, "thcsr_ack");
        apb_read(12'h004, HALT ? 32'd3 : 32'd5, "halt_frozen_a");
        repeat (3) @(negedge clk);
        apb_read(12'h004, HALT ? 32'd3 : 32'd9, "halt_frozen_b");
        dbg_mode = 1'b0;
        apb_read(12'h004, HALT ? 32'd4 : 32'd10, "halt_resume");

        // Reset in the middle of a write.
        @(negedge clk);
        paddr = 12'h014; pwdata = 32'h1; pstrb = 4'hF;
        wr_en = 1'b1; pready = 1'b1; rst = 1'b1;
        @(negedge clk);
        wr_en = 1'b0; pready = 1'b0; pstrb = 4'h0; rst = 1'b0;
        apb_read(12'h014, 32'h0, "rst_mid_tier");
        apb_read(12'h000, 32'h0000_0100, "rst_mid_tcr");
        apb_read(12'h004, 32'h0, "rst_mid_tdr0");

        if (sb_q.size() != 0) begin
            mismatched++;
            $display("FAIL scoreboard_leftover: got %0d entries expected 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
